// File: rtl/serial_word_queue_if.sv
// serial_word_queue_if
//   Bundles the serial write side, the pop/flush controls and all status
//   outputs of serial_word_queue.
//   Handshake: there is no valid/ready pair. Each rising level transition of
//   write_in delivers the data_in bit, and each rising transition of dequeue_in
//   pops one word. status_out=1 means further bits are refused (and flagged).
//   data_valid pulses for one cycle whenever data_out takes a new word.
//   master modport: the producer/consumer environment (drives the controls)
//   slave  modport: the queue itself (drives data_out and the status flags)
interface serial_word_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic                           data_in;
    logic                           write_in;
    logic                           dequeue_in;
    logic                           flush_in;
    logic [WIDTH-1:0]               data_out;
    logic                           data_valid;
    logic                           status_out;
    logic                           full;
    logic                           empty;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           overflow_err;
    logic                           underflow_err;

    modport master (
        output data_in, write_in, dequeue_in, flush_in,
        input  data_out, data_valid, status_out, full, empty, count,
               overflow_err, underflow_err
    );

    modport slave (
        input  data_in, write_in, dequeue_in, flush_in,
        output data_out, data_valid, status_out, full, empty, count,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/serial_word_queue.sv
// serial_word_queue
//   Serial-to-parallel receive queue. Bits arrive one per rising edge of
//   write_in, are assembled into WIDTH-bit words and stored in a DEPTH-entry
//   FIFO that is popped one word per rising edge of dequeue_in.
// Ports
//   clock1M   : single clock, everything on its rising edge
//   reset     : synchronous, active-high
//   bus       : serial_word_queue_if slave (controls in, data/status out)
//   state_dbg : assembler FSM state (0 = COLLECT, 1 = HOLD)
module serial_word_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clock1M,
    input  logic                  reset,
    serial_word_queue_if.slave    bus,
    output logic                  state_dbg
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q, dq_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_edge, dq_edge, pop, push, push_ok;
    logic [WIDTH-1:0] shifted, push_word;

    always_comb begin
        wr_edge = bus.write_in & ~wr_q;
        dq_edge = bus.dequeue_in & ~dq_q;
        pop     = dq_edge & ~empty_q;
        // A simultaneous pop frees the slot this push needs.
        push_ok = ~full_q | pop;

        if (MSB_FIRST != 0) shifted = {sh_q[WIDTH-2:0], bus.data_in};
        else                shifted = {bus.data_in, sh_q[WIDTH-1:1]};

        state_d      = state_q;
        sh_d         = sh_q;
        hold_d       = hold_q;
        bit_cnt_d    = bit_cnt_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        push         = 1'b0;
        push_word    = shifted;
        data_out_d   = data_out_q;
        data_valid_d = pop;
        rd_ptr_d     = rd_ptr_q;

        if (bus.flush_in) begin
            // Flush drops any partial or held word; FIFO state is kept.
            state_d   = S_COLLECT;
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (wr_edge) begin
                        if (bit_cnt_q == BW'(WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            if (push_ok) begin
                                push = 1'b1;
                            end else begin
                                hold_d  = shifted;
                                state_d = S_HOLD;
                            end
                        end else begin
                            sh_d      = shifted;
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (wr_edge) ovf_d = 1'b1;
                    if (push_ok) begin
                        push      = 1'b1;
                        push_word = hold_q;
                        state_d   = S_COLLECT;
                    end
                end
                default: state_d = S_COLLECT;
            endcase
            if (dq_edge && empty_q) unf_d = 1'b1;
        end

        if (pop) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clock1M) begin
        if (reset) begin
            state_q      <= S_COLLECT;
            // Loading 1 hides a level already high when reset releases.
            wr_q         <= 1'b1;
            dq_q         <= 1'b1;
            sh_q         <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= bus.write_in;
            dq_q         <= bus.dequeue_in;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Storage needs no reset: count and pointers define what is valid.
    always_ff @(posedge clock1M) begin
        if (push && !reset) mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.status_out    = (state_q == S_HOLD);
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.count         = count_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
    assign state_dbg         = state_q;
endmodule
